// File: rtl/role_pkg.sv
// Shared constants and types for the JOJO role/hit logic.
// Latency: none (declarations only).
// Backpressure: none.
package role_pkg;

  localparam int MAX_X  = 640;
  localparam int MAX_Y  = 480;
  localparam int T_W    = 32;
  localparam int HP_MAX = 3;
  localparam int HP_W   = $clog2(HP_MAX + 1);

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } hit_state_t;

  // Width of an index selecting one of n items; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/role_hit_manager_if.sv
// Position inputs and hit/hp status outputs of the role hit manager.
// Latency: none (wiring only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface role_hit_manager_if
  import role_pkg::*;
#(
  parameter int NUM_ENEMY = 4,
  parameter int HP_MAX    = role_pkg::HP_MAX
);
  localparam int HPW  = $clog2(HP_MAX + 1);
  localparam int IDXW = idx_width(NUM_ENEMY);

  logic [9:0]              jojo_x;
  logic [9:0]              jojo_y;
  logic [10*NUM_ENEMY-1:0] enemy_x;
  logic [10*NUM_ENEMY-1:0] enemy_y;
  logic [NUM_ENEMY-1:0]    enemy_valid;
  logic                    frame_tick;
  logic                    heal;
  logic [HPW-1:0]          hp;
  logic                    hit_pulse;
  logic [IDXW-1:0]         hit_index;
  logic                    invincible;
  logic                    jojo_visible;
  logic                    game_over;

  modport master (
    output jojo_x, jojo_y, enemy_x, enemy_y, enemy_valid, frame_tick, heal,
    input  hp, hit_pulse, hit_index, invincible, jojo_visible, game_over
  );

  modport slave (
    input  jojo_x, jojo_y, enemy_x, enemy_y, enemy_valid, frame_tick, heal,
    output hp, hit_pulse, hit_index, invincible, jojo_visible, game_over
  );

endinterface

// File: rtl/role_box_overlap.sv
// Bounding-box overlap test between two square tiles (a = JOJO, b = enemy).
// Latency: combinational.
// Backpressure: none.
module role_box_overlap
  import role_pkg::*;
#(
  parameter int TW = role_pkg::T_W
) (
  input  logic [9:0] ax,
  input  logic [9:0] ay,
  input  logic [9:0] bx,
  input  logic [9:0] by,
  input  logic       valid,
  output logic       hit
);
  localparam logic [10:0] TW11 = 11'(TW);

  // Extend to 11 bits so coordinate + tile size can never wrap.
  logic [10:0] ax_e, ay_e, bx_e, by_e;
  assign ax_e = {1'b0, ax};
  assign ay_e = {1'b0, ay};
  assign bx_e = {1'b0, bx};
  assign by_e = {1'b0, by};

  // Strict compares: tiles that only touch along an edge do not overlap.
  assign hit = valid
             && (bx_e < ax_e + TW11) && (ax_e < bx_e + TW11)
             && (by_e < ay_e + TW11) && (ay_e < by_e + TW11);

endmodule

// File: rtl/role_hit_manager.sv
// Per-frame enemy/JOJO overlap check, hp bookkeeping, invincibility blink, game over.
// Latency: hit_pulse and status update 2 edges after frame_tick is sampled.
// Backpressure: none; overlaps during invincibility or after death are dropped.
module role_hit_manager
  import role_pkg::*;
#(
  parameter int NUM_ENEMY    = 4,
  parameter int T_W          = role_pkg::T_W,
  parameter int HP_MAX       = role_pkg::HP_MAX,
  parameter int INV_CYCLES   = 50000000,
  parameter int BLINK_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  role_hit_manager_if.slave  bus
);
  localparam int HPW  = $clog2(HP_MAX + 1);
  localparam int IDXW = idx_width(NUM_ENEMY);
  localparam int INVW = $clog2(INV_CYCLES + 1);
  localparam int BLKW = $clog2(BLINK_CYCLES + 1);

  logic [NUM_ENEMY-1:0] ovl;

  for (genvar i = 0; i < NUM_ENEMY; i++) begin : g_box
    role_box_overlap #(.TW(T_W)) u_box (
      .ax   (bus.jojo_x),
      .ay   (bus.jojo_y),
      .bx   (bus.enemy_x[10*i +: 10]),
      .by   (bus.enemy_y[10*i +: 10]),
      .valid(bus.enemy_valid[i]),
      .hit  (ovl[i])
    );
  end

  logic [NUM_ENEMY-1:0] ovl_vec_q, ovl_vec_d;
  logic                 hit_vld_q, hit_vld_d;

  // Stage 1: capture the overlap vector only while positions are stable.
  always_comb begin
    hit_vld_d = bus.frame_tick;
    ovl_vec_d = bus.frame_tick ? ovl : ovl_vec_q;
  end

  // Stage 1 registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovl_vec_q <= '0;
      hit_vld_q <= 1'b0;
    end else begin
      ovl_vec_q <= ovl_vec_d;
      hit_vld_q <= hit_vld_d;
    end
  end

  logic [IDXW-1:0] first_idx;

  // Lowest-index overlapping enemy wins the report.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_ENEMY - 1; i >= 0; i--) begin
      if (ovl_vec_q[i]) first_idx = IDXW'(i);
    end
  end

  hit_state_t      state_q, state_d;
  logic [HPW-1:0]  hp_q, hp_d;
  logic            hit_pulse_q, hit_pulse_d;
  logic [IDXW-1:0] hit_index_q, hit_index_d;
  logic [INVW-1:0] inv_cnt_q, inv_cnt_d;
  logic [BLKW-1:0] blink_cnt_q, blink_cnt_d;
  logic            visible_q, visible_d;
  logic            invincible_q, invincible_d;
  logic            game_over_q, game_over_d;
  logic            hit_now;
  logic            heal_ok;

  assign hit_now = hit_vld_q && (|ovl_vec_q);
  assign heal_ok = bus.heal && (hp_q != HPW'(HP_MAX));

  // Stage 2: hit/heal/invincibility state machine with registered outputs.
  always_comb begin
    state_d      = state_q;
    hp_d         = hp_q;
    hit_pulse_d  = 1'b0;
    hit_index_d  = hit_index_q;
    inv_cnt_d    = inv_cnt_q;
    blink_cnt_d  = blink_cnt_q;
    visible_d    = visible_q;
    invincible_d = invincible_q;
    game_over_d  = game_over_q;
    case (state_q)
      ALIVE: begin
        if (hit_now) begin
          // A coinciding heal is dropped: the hit takes priority.
          hp_d        = hp_q - HPW'(1);
          hit_pulse_d = 1'b1;
          hit_index_d = first_idx;
          if (hp_q == HPW'(1)) begin
            state_d      = DEAD;
            game_over_d  = 1'b1;
            visible_d    = 1'b0;
            invincible_d = 1'b0;
          end else begin
            state_d      = INVULN;
            inv_cnt_d    = INVW'(INV_CYCLES - 1);
            blink_cnt_d  = '0;
            visible_d    = 1'b0;
            invincible_d = 1'b1;
          end
        end else if (heal_ok) begin
          hp_d = hp_q + HPW'(1);
        end
      end
      INVULN: begin
        if (heal_ok) hp_d = hp_q + HPW'(1);
        if (inv_cnt_q == '0) begin
          state_d      = ALIVE;
          invincible_d = 1'b0;
          visible_d    = 1'b1;
          blink_cnt_d  = '0;
        end else begin
          inv_cnt_d = inv_cnt_q - INVW'(1);
          if (blink_cnt_q == BLKW'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            visible_d   = ~visible_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BLKW'(1);
          end
        end
      end
      DEAD: begin
        // Terminal until reset.
      end
      default: state_d = ALIVE;
    endcase
  end

  // Stage 2 registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ALIVE;
      hp_q         <= HPW'(HP_MAX);
      hit_pulse_q  <= 1'b0;
      hit_index_q  <= '0;
      inv_cnt_q    <= '0;
      blink_cnt_q  <= '0;
      visible_q    <= 1'b1;
      invincible_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      hp_q         <= hp_d;
      hit_pulse_q  <= hit_pulse_d;
      hit_index_q  <= hit_index_d;
      inv_cnt_q    <= inv_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      visible_q    <= visible_d;
      invincible_q <= invincible_d;
      game_over_q  <= game_over_d;
    end
  end

  assign bus.hp           = hp_q;
  assign bus.hit_pulse    = hit_pulse_q;
  assign bus.hit_index    = hit_index_q;
  assign bus.invincible   = invincible_q;
  assign bus.jojo_visible = visible_q;
  assign bus.game_over    = game_over_q;

endmodule

// File: doc/role_hit_manager.md
Name: role_hit_manager

Overview:
Downstream consumer of the enemy role blocks' (bottom mask and siblings) position outputs. Once per frame it checks bounding-box overlap of each enemy tile against JOJO's tile. It also maintains JOJO's hit points, the post-hit invincibility window with sprite blink, and the game-over flag. Outputs feed the JOJO renderer (visibility), the HUD (hp) and the top-level game FSM (game_over).

Parameters:
NUM_ENEMY, 4, number of enemy role inputs
T_W, 32, tile width/height in pixels (JOJO and enemies)
HP_MAX, 3, hit points after reset
INV_CYCLES, 50000000, invincibility duration in clk cycles
BLINK_CYCLES, 5000000, half-period of JOJO blink while invincible

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
jojo_x  in  10  JOJO tile top-left x
jojo_y  in  10  JOJO tile top-left y
enemy_x  in  10*NUM_ENEMY  packed enemy top-left x, enemy i at bits [10i+9:10i]
enemy_y  in  10*NUM_ENEMY  packed enemy top-left y
enemy_valid  in  NUM_ENEMY  1 = enemy i active; inactive enemies never hit
frame_tick  in  1  one-cycle pulse at start of vblank; positions stable
heal  in  1  one-cycle pulse, +1 hp
hp  out  $clog2(HP_MAX+1)  current hit points
hit_pulse  out  1  one-cycle pulse when damage is applied
hit_index  out  $clog2(NUM_ENEMY)  lowest-index enemy of the last applied hit
invincible  out  1  high during the invincibility window
jojo_visible  out  1  renderer enable for JOJO sprite
game_over  out  1  sticky, high once hp reaches 0

Behaviour:
- Reset (async) values: hp=HP_MAX, state ALIVE, hit_pulse=0, hit_index=0, invincible=0, jojo_visible=1, game_over=0, all counters 0.
- Overlap for enemy i: enemy_valid[i] && ex < jx+T_W && jx < ex+T_W && ey < jy+T_W && jy < ey+T_W. All sums are computed at 11 bits, so there is no wrap (jx=620, ex=0 gives no hit). Touching edges (|dx|=T_W) is not a hit.
- Stage 1: on the edge sampling frame_tick=1, register the overlap vector and set hit_vld. Overlap is never evaluated outside frame_tick.
- Stage 2 (FSM, acts on the next edge): hit_pulse is high for exactly the cycle following that edge. Total latency: hit_pulse visible 2 edges after frame_tick is sampled.
- FSM states ALIVE, INVULN, DEAD.
- ALIVE with hit_vld && |vec|: hp-=1, hit_pulse=1, hit_index=lowest set bit. If the new hp==0, go to DEAD. Otherwise go to INVULN, load inv_cnt=INV_CYCLES-1 and blink_cnt=0.
- INVULN: inv_cnt decrements each clk and overlaps are ignored (no hit_pulse). At inv_cnt==0, go to ALIVE on the next edge.
- DEAD: game_over=1, invincible=0, jojo_visible=0. All inputs are ignored until reset.
- heal: in ALIVE/INVULN, hp=min(hp+1, HP_MAX). Ignored in DEAD. If heal and an applied hit coincide, the hit is applied and the heal is dropped.
- invincible = (state==INVULN).
- jojo_visible: 1 in ALIVE. In INVULN it starts at 0 on entry and toggles each time blink_cnt reaches BLINK_CYCLES-1 (blink_cnt then wraps to 0). 0 in DEAD.
- hit_index holds its value between hits.
- Reset mid-INVULN or mid-DEAD returns immediately to the reset values.

Decomposition:
- Shared package role_pkg: MAX_X=640, MAX_Y=480, T_W=32, hit-state enum {ALIVE, INVULN, DEAD}, HP width constant.
- One sub-module, role_box_overlap: combinational 11-bit bounding-box compare with inputs ax, ay, bx, by, valid and output hit. Instantiated NUM_ENEMY times via generate.
- The FSM, counters and priority encoder stay in role_hit_manager.

Test Plan (sim params INV_CYCLES=20, BLINK_CYCLES=4, HP_MAX=3):
1. Assert reset, release -> hp=3, jojo_visible=1, invincible=0, game_over=0, hit_pulse never high without frame_tick.
2. jojo=(120,310), enemy0=(100,300) valid, frame_tick at T -> hit_pulse high only in cycle T+2, hp=2, hit_index=0, invincible=1, jojo_visible=0.
3. Boundary: jojo=(100,300), enemy0 x=132 -> no hit. Enemy0 x=131 -> hit. jojo_x=620, enemy_x=0 -> no hit. Overlapping enemy with valid=0 -> no hit.
4. In INVULN, overlap held with frame_tick every 3 cycles -> hp stays 2. jojo_visible toggles every 4 cycles. invincible drops after 20 cycles. Next overlapping frame_tick -> hp=1.
5. Enemies 1 and 3 overlap simultaneously -> hit_index=1. Heal pulse in the same cycle as the hit -> hp decrements only. A later heal raises hp, saturating at 3.
6. Three spaced hits -> hp=0, game_over=1, jojo_visible=0. Heal is ignored. Reset asserted mid-INVULN -> immediate hp=3, state ALIVE.
